// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//
// In-order retirement queue for the Tomasulo core. It sits directly upstream
// of the register file. Every issued instruction gets a rename tag in 1..DEPTH
// (tag 0 means "no dependency"). Results broadcast on the CDB are captured
// against that tag and retired strictly in program order, at most one per
// cycle. A mispredicted branch reaching the head is retired normally. It also
// raises a one-cycle flush with the redirect PC and empties the buffer.
//
// Ports
//   clk_in, rst_in      clock (rising edge), asynchronous active-low reset
//   rdy_in              global ready; 0 freezes all state
//   issue_*             allocation handshake; issue_tag is the current tail
//   cdb_*               result broadcast (data, or target PC for a branch)
//   query_tag/ready/data x2
//                       operand lookup for the register file's qj/qk,
//                       with same-cycle CDB forwarding
//   commit_*            registered one-cycle retire pulse toward the register
//                       file (mode / rob_depend / rob_data / rd)
//   flush_out, flush_pc registered one-cycle pipeline flush and redirect PC
// ---------------------------------------------------------------------------
module reorder_buffer #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 15
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,

  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  output logic             issue_ready,
  output logic [TAG_W-1:0] issue_tag,

  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  input  logic             cdb_mispredict,

  input  logic [TAG_W-1:0] query_tag1,
  input  logic [TAG_W-1:0] query_tag2,
  output logic             query_ready1,
  output logic             query_ready2,
  output logic [31:0]      query_data1,
  output logic [31:0]      query_data2,

  output logic             commit_valid,
  output logic [TAG_W-1:0] commit_tag,
  output logic [31:0]      commit_data,
  output logic [4:0]       commit_rd,

  output logic             flush_out,
  output logic [31:0]      flush_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [TAG_W-1:0] FIRST_TAG = TAG_W'(1);
  localparam logic [TAG_W-1:0] LAST_TAG  = TAG_W'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  // Per-entry state, indexed directly by tag. Slot 0 exists only so that a
  // tag can index the vectors without translation. Its busy bit is never set,
  // so tag 0 can never match.
  logic [DEPTH:0] busy;
  logic [DEPTH:0] ready;
  logic [DEPTH:0] mispredict;
  logic [4:0]     rd_mem   [0:DEPTH];
  logic [31:0]    data_mem [0:DEPTH];

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic full;
  logic head_done;
  logic flush_now;
  logic retire;
  logic flush;
  logic do_issue;
  logic cdb_hit;

  // Pointers cycle 1..DEPTH and skip the reserved tag 0.
  function automatic logic [TAG_W-1:0] next_ptr(input logic [TAG_W-1:0] p);
    return (p == LAST_TAG) ? FIRST_TAG : p + TAG_W'(1);
  endfunction

  // -------------------------------------------------------------------------
  // Control decode
  // -------------------------------------------------------------------------
  assign full      = (count == FULL_CNT);
  assign head_done = busy[head] & ready[head];
  // flush_now is independent of rdy_in. A mispredicted head blocks issue even
  // while paused, so nothing younger can slip in before the flush.
  assign flush_now = head_done & mispredict[head];
  assign retire    = rdy_in & head_done;
  assign flush     = retire & mispredict[head];

  // issue_ready deliberately ignores a retirement on the same edge. A full
  // buffer only reopens the cycle after its head leaves.
  assign issue_ready = rdy_in & ~full & ~flush_now;
  assign issue_tag   = tail;
  assign do_issue    = issue_valid & issue_ready;

  assign cdb_hit = rdy_in & cdb_valid & (cdb_tag != '0) & busy[cdb_tag];

  // -------------------------------------------------------------------------
  // Entry flags and pointers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. Every read in this
  // block sees the pre-edge value, and a later assignment to the same bit
  // overrides an earlier one. That is how a retire clear wins over a CDB
  // write to the head entry.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy       <= '0;
      ready      <= '0;
      mispredict <= '0;
      head       <= FIRST_TAG;
      tail       <= FIRST_TAG;
      count      <= '0;
    end else if (flush) begin
      // The mispredicted head is retired through the output register below.
      // Every younger entry is on the wrong path, so all of them are dropped.
      busy       <= '0;
      ready      <= '0;
      mispredict <= '0;
      head       <= FIRST_TAG;
      tail       <= FIRST_TAG;
      count      <= '0;
    end else begin
      if (cdb_hit) begin
        ready[cdb_tag]      <= 1'b1;
        mispredict[cdb_tag] <= cdb_mispredict;
      end
      if (retire) begin
        busy[head]       <= 1'b0;
        ready[head]      <= 1'b0;
        mispredict[head] <= 1'b0;
        head             <= next_ptr(head);
      end
      // The tail slot is never busy while issue is possible, so issue cannot
      // collide with a CDB write or a retirement.
      if (do_issue) begin
        busy[tail]       <= 1'b1;
        ready[tail]      <= 1'b0;
        mispredict[tail] <= 1'b0;
        tail             <= next_ptr(tail);
      end
      count <= count + CNT_W'(do_issue) - CNT_W'(retire);
    end
  end

  // -------------------------------------------------------------------------
  // Entry payload
  // -------------------------------------------------------------------------
  // NOTE: the payload arrays have no reset. Their contents are only observed
  // through an entry that is busy and ready, and both flags do reset. That
  // leaves these arrays as plain RAM without a reset tree.
  always_ff @(posedge clk_in) begin
    if (cdb_hit) begin
      data_mem[cdb_tag] <= cdb_data;
    end
    if (do_issue) begin
      rd_mem[tail] <= issue_rd;
    end
  end

  // -------------------------------------------------------------------------
  // Retire / flush output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      commit_valid <= 1'b0;
      commit_tag   <= '0;
      commit_data  <= '0;
      commit_rd    <= '0;
      flush_out    <= 1'b0;
      flush_pc     <= '0;
    end else if (retire) begin
      commit_valid <= 1'b1;
      commit_tag   <= head;
      commit_data  <= data_mem[head];
      commit_rd    <= rd_mem[head];
      flush_out    <= mispredict[head];
      if (mispredict[head]) begin
        flush_pc <= data_mem[head];
      end
    end else begin
      // A pause lands here too, because retire requires rdy_in. The pulses
      // drop and the payload registers hold their last value.
      commit_valid <= 1'b0;
      flush_out    <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Operand query with same-cycle CDB forwarding
  // -------------------------------------------------------------------------
  // NOTE: every output of an always_comb gets a default first. No path can
  // then leave it unassigned, so no latch is inferred.
  always_comb begin
    query_ready1 = 1'b0;
    query_data1  = '0;
    if (busy[query_tag1] && ready[query_tag1]) begin
      query_ready1 = 1'b1;
      query_data1  = data_mem[query_tag1];
    end else if (cdb_valid && (query_tag1 != '0) && (cdb_tag == query_tag1)) begin
      query_ready1 = 1'b1;
      query_data1  = cdb_data;
    end
  end

  always_comb begin
    query_ready2 = 1'b0;
    query_data2  = '0;
    if (busy[query_tag2] && ready[query_tag2]) begin
      query_ready2 = 1'b1;
      query_data2  = data_mem[query_tag2];
    end else if (cdb_valid && (query_tag2 != '0) && (cdb_tag == query_tag2)) begin
      query_ready2 = 1'b1;
      query_data2  = cdb_data;
    end
  end

  // -------------------------------------------------------------------------
  // Structural invariants
  // -------------------------------------------------------------------------
  a_count_range: assert property (@(posedge clk_in) disable iff (!rst_in)
    count <= FULL_CNT);
  a_head_nonzero: assert property (@(posedge clk_in) disable iff (!rst_in)
    head != '0 && head <= LAST_TAG);
  a_tail_nonzero: assert property (@(posedge clk_in) disable iff (!rst_in)
    tail != '0 && tail <= LAST_TAG);
  a_flush_has_commit: assert property (@(posedge clk_in) disable iff (!rst_in)
    flush_out |-> commit_valid);

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
//
// Directed scenarios for reset, basic retire latency, out-of-order completion,
// full-buffer wrap, mispredict flush, query forwarding, pause and mid-stream
// reset. These are followed by a randomized run that is checked against a
// program-order queue model of the reorder buffer.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;

  localparam int TAG_W = 4;
  localparam int DEPTH = 15;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic             rdy_in;
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic             issue_ready;
  logic [TAG_W-1:0] issue_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             cdb_mispredict;
  logic [TAG_W-1:0] query_tag1, query_tag2;
  logic             query_ready1, query_ready2;
  logic [31:0]      query_data1, query_data2;
  logic             commit_valid;
  logic [TAG_W-1:0] commit_tag;
  logic [31:0]      commit_data;
  logic [4:0]       commit_rd;
  logic             flush_out;
  logic [31:0]      flush_pc;

  int tests = 0;
  int fails = 0;

  reorder_buffer #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_mispredict(cdb_mispredict),
    .query_tag1(query_tag1), .query_tag2(query_tag2),
    .query_ready1(query_ready1), .query_ready2(query_ready2),
    .query_data1(query_data1), .query_data2(query_data2),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .commit_data(commit_data), .commit_rd(commit_rd),
    .flush_out(flush_out), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  // ------------------------------------------------------------------
  // Reference model: in-flight instructions in program order
  // ------------------------------------------------------------------
  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  rd;
    bit          done;
    bit          misp;
    logic [31:0] val;
  } ent_t;

  ent_t        mq[$];
  int          m_next_tag;
  logic        e_cv, e_fo;
  logic [3:0]  e_ct;
  logic [31:0] e_cd, e_fp;
  logic [4:0]  e_cr;

  task automatic model_reset();
    mq.delete();
    m_next_tag = 1;
    e_cv = 1'b0; e_ct = '0; e_cd = '0; e_cr = '0; e_fo = 1'b0; e_fp = '0;
  endtask

  function automatic logic model_issue_ready();
    if (!rdy_in) return 1'b0;
    if (mq.size() >= DEPTH) return 1'b0;
    if (mq.size() > 0 && mq[0].done && mq[0].misp) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [32:0] model_query(input logic [3:0] t);
    foreach (mq[i]) if (mq[i].tag == t && mq[i].done) return {1'b1, mq[i].val};
    if (t != 4'd0 && cdb_valid && cdb_tag == t) return {1'b1, cdb_data};
    return 33'h0;
  endfunction

  // Applies one clock edge using the inputs that were held across it.
  task automatic model_edge();
    bit   ret;
    bit   acc;
    ent_t h;
    if (!rdy_in) begin
      e_cv = 1'b0; e_fo = 1'b0;
      return;
    end
    ret = (mq.size() > 0) && mq[0].done;
    acc = issue_valid && model_issue_ready();
    if (ret) begin
      h = mq[0];
      e_cv = 1'b1; e_ct = h.tag; e_cd = h.val; e_cr = h.rd; e_fo = h.misp;
      if (h.misp) e_fp = h.val;
    end else begin
      e_cv = 1'b0; e_fo = 1'b0;
    end
    if (cdb_valid && cdb_tag != 4'd0) begin
      foreach (mq[i]) if (mq[i].tag == cdb_tag) begin
        mq[i].done = 1'b1; mq[i].val = cdb_data; mq[i].misp = cdb_mispredict;
      end
    end
    if (ret) void'(mq.pop_front());
    if (ret && h.misp) begin
      mq.delete();
      m_next_tag = 1;
    end else if (acc) begin
      mq.push_back('{tag: 4'(m_next_tag), rd: issue_rd, done: 1'b0, misp: 1'b0, val: 32'h0});
      m_next_tag = (m_next_tag == DEPTH) ? 1 : m_next_tag + 1;
    end
  endtask

  // ------------------------------------------------------------------
  // Stimulus helpers (no comparisons)
  // ------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; issue_valid = 1'b0; issue_rd = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; cdb_mispredict = 1'b0;
    query_tag1 = '0; query_tag2 = '0;
  endtask

  task automatic apply_reset();
    idle();
    rst_in = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;
    model_reset();
    #1;
  endtask

  // ------------------------------------------------------------------
  // Scenarios
  // ------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL reset_commit_valid: got %0h want 0", commit_valid); end
    tests++; if (commit_tag !== 4'd0) begin fails++; $display("FAIL reset_commit_tag: got %0h want 0", commit_tag); end
    tests++; if (commit_data !== 32'd0) begin fails++; $display("FAIL reset_commit_data: got %0h want 0", commit_data); end
    tests++; if (commit_rd !== 5'd0) begin fails++; $display("FAIL reset_commit_rd: got %0h want 0", commit_rd); end
    tests++; if (flush_out !== 1'b0 || flush_pc !== 32'd0) begin fails++; $display("FAIL reset_flush: got %0h/%0h want 0/0", flush_out, flush_pc); end
    tests++; if (issue_ready !== 1'b1 || issue_tag !== 4'd1) begin fails++; $display("FAIL reset_issue: got ready %0h tag %0h want 1/1", issue_ready, issue_tag); end
  endtask

  task automatic test_basic();
    apply_reset();
    issue_valid = 1'b1; issue_rd = 5'd5;
    #1;
    tests++; if (issue_tag !== 4'd1) begin fails++; $display("FAIL basic_issue_tag: got %0h want 1", issue_tag); end
    tick();
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_data = 32'h1234;
    tick();                                      // edge N: result captured
    cdb_valid = 1'b0;
    tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL basic_early_commit: got %0h want 0", commit_valid); end
    tick();                                      // edge N+1: retire
    tests++; if (commit_valid !== 1'b1 || commit_tag !== 4'd1 || commit_rd !== 5'd5 || commit_data !== 32'h1234) begin
      fails++; $display("FAIL basic_commit: got v%0h t%0h rd%0h d%0h want v1 t1 rd5 d1234", commit_valid, commit_tag, commit_rd, commit_data);
    end
    tick();
    tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL basic_pulse_width: got %0h want 0", commit_valid); end
  endtask

  task automatic test_in_order();
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i);
      tick();
    end
    issue_valid = 1'b0;
    for (int i = 3; i >= 1; i--) begin
      cdb_valid = 1'b1; cdb_tag = 4'(i); cdb_data = 32'(i * 256);
      tick();
      tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL order_no_early_commit_%0d: got %0h want 0", i, commit_valid); end
    end
    cdb_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      tests++; if (commit_valid !== 1'b1 || commit_tag !== 4'(i) || commit_data !== 32'(i * 256) || commit_rd !== 5'(i)) begin
        fails++; $display("FAIL order_commit_%0d: got v%0h t%0h d%0h rd%0h want v1 t%0h d%0h rd%0h",
                          i, commit_valid, commit_tag, commit_data, commit_rd, i, i * 256, i);
      end
    end
    tick();
    tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL order_drain: got %0h want 0", commit_valid); end
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i);
      #1;
      tests++; if (issue_tag !== 4'(i) || issue_ready !== 1'b1) begin fails++; $display("FAIL full_alloc_%0d: got tag %0h ready %0h want %0h/1", i, issue_tag, issue_ready, i); end
      tick();
    end
    tests++; if (issue_ready !== 1'b0 || issue_tag !== 4'd1) begin fails++; $display("FAIL full_ready: got ready %0h tag %0h want 0/1", issue_ready, issue_tag); end
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_data = 32'hAA;   // issue_valid still held
    tick();
    cdb_valid = 1'b0;
    tests++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL full_retire_edge_ready: got %0h want 0", issue_ready); end
    tick();                                                 // retire; no allocation
    tests++; if (commit_valid !== 1'b1 || commit_tag !== 4'd1 || commit_rd !== 5'd1 || commit_data !== 32'hAA) begin
      fails++; $display("FAIL full_retire: got v%0h t%0h rd%0h d%0h want v1 t1 rd1 dAA", commit_valid, commit_tag, commit_rd, commit_data);
    end
    tests++; if (issue_ready !== 1'b1 || issue_tag !== 4'd1) begin fails++; $display("FAIL full_wrap_tag: got ready %0h tag %0h want 1/1", issue_ready, issue_tag); end
    tick();                                                 // allocates tag 1
    issue_valid = 1'b0;
    #1;
    tests++; if (issue_ready !== 1'b0 || issue_tag !== 4'd2) begin fails++; $display("FAIL full_refill: got ready %0h tag %0h want 0/2", issue_ready, issue_tag); end
  endtask

  task automatic test_mispredict();
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i + 10);
      tick();
    end
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_data = 32'h80; cdb_mispredict = 1'b1;
    tick();
    cdb_valid = 1'b0; cdb_mispredict = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd4;                    // must be dropped
    #1;
    tests++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL misp_issue_blocked: got %0h want 0", issue_ready); end
    tick();                                                 // flush edge
    issue_valid = 1'b0;
    tests++; if (commit_valid !== 1'b1 || commit_tag !== 4'd1 || commit_data !== 32'h80 || commit_rd !== 5'd11) begin
      fails++; $display("FAIL misp_commit: got v%0h t%0h d%0h rd%0h want v1 t1 d80 rdB", commit_valid, commit_tag, commit_data, commit_rd);
    end
    tests++; if (flush_out !== 1'b1 || flush_pc !== 32'h80) begin fails++; $display("FAIL misp_flush: got %0h pc %0h want 1/80", flush_out, flush_pc); end
    #1;
    tests++; if (issue_ready !== 1'b1 || issue_tag !== 4'd1) begin fails++; $display("FAIL misp_pointers: got ready %0h tag %0h want 1/1", issue_ready, issue_tag); end
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'h55;   // late, wrong-path
    tick();
    cdb_valid = 1'b0;
    tests++; if (flush_out !== 1'b0 || commit_valid !== 1'b0) begin fails++; $display("FAIL misp_pulse: got flush %0h commit %0h want 0/0", flush_out, commit_valid); end
    tick();
    tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL misp_late_cdb: got %0h want 0", commit_valid); end
    issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    tests++; if (issue_tag !== 4'd1) begin fails++; $display("FAIL misp_reissue_tag: got %0h want 1", issue_tag); end
    tick();
    issue_valid = 1'b0;
    query_tag1 = 4'd1;
    #1;
    tests++; if (issue_tag !== 4'd2 || query_ready1 !== 1'b0) begin fails++; $display("FAIL misp_after: got tag %0h qready %0h want 2/0", issue_tag, query_ready1); end
  endtask

  task automatic test_query();
    apply_reset();
    for (int i = 1; i <= 2; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i);
      tick();
    end
    issue_valid = 1'b0;
    query_tag1 = 4'd2; query_tag2 = 4'd0;
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'hBEEF;
    #1;
    tests++; if (query_ready1 !== 1'b1 || query_data1 !== 32'hBEEF) begin fails++; $display("FAIL query_forward: got %0h/%0h want 1/beef", query_ready1, query_data1); end
    tests++; if (query_ready2 !== 1'b0 || query_data2 !== 32'h0) begin fails++; $display("FAIL query_tag0: got %0h/%0h want 0/0", query_ready2, query_data2); end
    tick();
    cdb_valid = 1'b0;
    query_tag2 = 4'd1;
    #1;
    tests++; if (query_ready1 !== 1'b1 || query_data1 !== 32'hBEEF) begin fails++; $display("FAIL query_stored: got %0h/%0h want 1/beef", query_ready1, query_data1); end
    tests++; if (query_ready2 !== 1'b0) begin fails++; $display("FAIL query_not_ready: got %0h want 0", query_ready2); end
    query_tag2 = 4'd0; cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_data = 32'h77;
    #1;
    tests++; if (query_ready2 !== 1'b0) begin fails++; $display("FAIL query_tag0_cdb0: got %0h want 0", query_ready2); end
    cdb_valid = 1'b0;
  endtask

  task automatic test_pause_and_reset();
    apply_reset();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_data = 32'h77;
    tick();                                     // head now ready
    rdy_in = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd3;        // ignored while paused
    cdb_data = 32'h99;                          // ignored while paused
    #1;
    tests++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL pause_issue_ready: got %0h want 0", issue_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (commit_valid !== 1'b0) begin fails++; $display("FAIL pause_commit_%0d: got %0h want 0", i, commit_valid); end
    end
    rdy_in = 1'b1; issue_valid = 1'b0; cdb_valid = 1'b0;
    #1;
    tests++; if (issue_tag !== 4'd2 || issue_ready !== 1'b1) begin fails++; $display("FAIL pause_pointers: got tag %0h ready %0h want 2/1", issue_tag, issue_ready); end
    tick();
    tests++; if (commit_valid !== 1'b1 || commit_tag !== 4'd1 || commit_data !== 32'h77 || commit_rd !== 5'd7) begin
      fails++; $display("FAIL pause_release_commit: got v%0h t%0h d%0h rd%0h want v1 t1 d77 rd7", commit_valid, commit_tag, commit_data, commit_rd);
    end
    rdy_in = 1'b0;
    tick();
    tests++; if (commit_valid !== 1'b0 || commit_tag !== 4'd1 || commit_data !== 32'h77) begin
      fails++; $display("FAIL pause_hold: got v%0h t%0h d%0h want v0 t1 d77", commit_valid, commit_tag, commit_data);
    end
    rdy_in = 1'b1;
    #1;
    rst_in = 1'b0;                              // between edges
    #1;
    tests++; if (commit_tag !== 4'd0 || commit_data !== 32'd0 || commit_rd !== 5'd0 || issue_tag !== 4'd1) begin
      fails++; $display("FAIL async_reset: got t%0h d%0h rd%0h itag%0h want 0/0/0/1", commit_tag, commit_data, commit_rd, issue_tag);
    end
    tick();
    rst_in = 1'b1;
    model_reset();
    #1;
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %0h want 1", issue_ready); end
  endtask

  task automatic test_random();
    logic [32:0] q1, q2;
    int          fails_at_start;
    apply_reset();
    fails_at_start = fails;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rdy_in         = ($urandom_range(0, 9) != 0);
      issue_valid    = 1'($urandom_range(0, 1));
      issue_rd       = 5'($urandom);
      cdb_valid      = ($urandom_range(0, 9) < 6);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        cdb_tag = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        cdb_tag = 4'($urandom_range(0, 15));
      cdb_data       = $urandom;
      cdb_mispredict = ($urandom_range(0, 19) == 0);
      query_tag1     = 4'($urandom_range(0, 15));
      query_tag2     = 4'($urandom_range(0, 15));
      #1;
      q1 = model_query(query_tag1);
      q2 = model_query(query_tag2);
      tests++; if (issue_ready !== model_issue_ready()) begin fails++; $display("FAIL rnd_issue_ready c%0d: got %0h want %0h", cyc, issue_ready, model_issue_ready()); end
      tests++; if (issue_tag !== 4'(m_next_tag)) begin fails++; $display("FAIL rnd_issue_tag c%0d: got %0h want %0h", cyc, issue_tag, m_next_tag); end
      tests++; if ({query_ready1, query_data1} !== q1) begin fails++; $display("FAIL rnd_query1 c%0d: got %0h want %0h", cyc, {query_ready1, query_data1}, q1); end
      tests++; if ({query_ready2, query_data2} !== q2) begin fails++; $display("FAIL rnd_query2 c%0d: got %0h want %0h", cyc, {query_ready2, query_data2}, q2); end
      tick();
      model_edge();
      tests++; if (commit_valid !== e_cv || commit_tag !== e_ct || commit_data !== e_cd || commit_rd !== e_cr) begin
        fails++; $display("FAIL rnd_commit c%0d: got v%0h t%0h d%0h rd%0h want v%0h t%0h d%0h rd%0h",
                          cyc, commit_valid, commit_tag, commit_data, commit_rd, e_cv, e_ct, e_cd, e_cr);
      end
      tests++; if (flush_out !== e_fo || flush_pc !== e_fp) begin fails++; $display("FAIL rnd_flush c%0d: got %0h/%0h want %0h/%0h", cyc, flush_out, flush_pc, e_fo, e_fp); end
      if (fails - fails_at_start > 10) break;   // keep the log short after a fault
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_in_order();
    test_full_wrap();
    test_mispredict();
    test_query();
    test_pause_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement queue for the Tomasulo core; sits directly upstream of the register file.
- Allocates a 4-bit rename tag per issued instruction and captures CDB results against that tag.
- Retires results strictly in program order. Each retirement drives the register file's ROB-update inputs: mode=1, rob_depend=tag, rob_data=value.
- Detects mispredicted branches at retirement and emits a pipeline flush with the redirect PC.

Parameters:
TAG_W, 4, tag width; tag 0 is reserved as "None" (no dependency)
DEPTH, 15, number of entries (2^TAG_W - 1); entries are addressed by tags 1..DEPTH

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  asynchronous, active-low reset
rdy_in  in  1  global ready; 0 = pause
issue_valid  in  1  issue unit presents an instruction
issue_rd  in  5  destination register (0 = none)
issue_ready  out  1  entry available this cycle
issue_tag  out  TAG_W  tag allocated if issue accepted (combinational, = tail)
cdb_valid  in  1  result broadcast
cdb_tag  in  TAG_W  tag of broadcast result
cdb_data  in  32  result value, or correct target PC for a branch
cdb_mispredict  in  1  broadcast is a mispredicted branch
query_tag1, query_tag2  in  TAG_W  operand tags from register file qj/qk
query_ready1, query_ready2  out  1  tagged value available (combinational)
query_data1, query_data2  out  32  tagged value
commit_valid  out  1  one-cycle retire pulse (register file mode)
commit_tag  out  TAG_W  retired tag (register file rob_depend)
commit_data  out  32  retired value (register file rob_data)
commit_rd  out  5  retired destination register
flush_out  out  1  one-cycle flush pulse
flush_pc  out  32  redirect PC

Behaviour:
- Reset (rst_in=0, asynchronous):
  - All entries not busy; head=tail=1; count=0.
  - commit_valid=0, commit_tag=0, commit_data=0, commit_rd=0, flush_out=0, flush_pc=0.
  - Reset asserted mid-operation discards all in-flight entries immediately.
- Per-entry state: busy, ready, mispredict, rd[4:0], data[31:0].
- Pointers:
  - head and tail cycle through 1..15; 15 wraps to 1, never 0.
  - count range 0..15; full is count==15; empty is count==0.
- issue_ready = rdy_in & !full & !flush_now.
  - flush_now is the condition "head entry busy & ready & mispredict".
- Issue: on an edge with issue_valid & issue_ready:
  - entry[tail] gets busy=1, ready=0, rd=issue_rd;
  - tail advances.
- Issue into a full buffer is not accepted, even if a retirement occurs on the same edge; the freed slot becomes visible next cycle.
- CDB write: on an edge with cdb_valid where entry[cdb_tag] is busy:
  - sets ready=1, data=cdb_data, mispredict=cdb_mispredict.
  - A CDB write to a non-busy tag or to tag 0 is ignored.
- Retire: on an edge where entry[head] is busy and ready (state before the edge):
  - entry is cleared; head advances;
  - registered outputs: commit_valid=1, commit_tag=head, commit_data, commit_rd, visible for exactly the next cycle.
  - On any other edge, commit_valid=0.
  - At most one retirement per cycle.
  - Latency: CDB write at edge N to the head entry → commit_valid high in the cycle after edge N+1.
- Simultaneous events on one edge:
  - issue, CDB write and retire all apply, each to a distinct entry.
  - count updates by +issue −retire.
- Mispredict retire:
  - Retirement proceeds as normal (commit_valid=1, so the register file clears the tag). In addition, flush_out=1 and flush_pc=entry data for one cycle.
  - On the same edge, all entries are cleared, head=tail=1, count=0.
  - Any issue on that edge is dropped, because issue_ready=0.
  - Clearing rename tags for all other registers on a flush is the register file's job, driven by flush_out.
- Query (combinational):
  - query_readyX=1 and query_dataX=data when entry[query_tagX] is busy and ready.
  - Otherwise, query_readyX=1 and query_dataX=cdb_data when cdb_valid and cdb_tag==query_tagX (same-cycle forwarding).
  - Otherwise query_readyX=0 and query_dataX=0. query_tagX=0 always gives query_readyX=0.
- rdy_in=0 (pause):
  - All entry and pointer state is frozen; CDB and issue are ignored.
  - commit_valid and flush_out are cleared at the edge; the other registered outputs hold.

Test Plan:
- Reset, then issue rd=5 → issue_tag=1; CDB tag=1, data=0x1234 at edge N → commit_valid=1, commit_tag=1, commit_rd=5, commit_data=0x1234 in the cycle after edge N+1.
- Issue tags 1,2,3; CDB completes 3, 2, 1 in that order → commits occur in order 1,2,3 on consecutive cycles, each with the matching data.
- Issue 15 entries → issue_ready=0 at count 15. Retire the head while issue_valid is held → no allocation that edge. Next issue gets tag 1 (wrap), count returns to 15.
- Issue tags 1,2,3; CDB tag=1 with mispredict=1, data=0x80 → commit pulse for tag 1, flush_out=1, flush_pc=0x80. Next cycle: count=0, the next issue gets tag 1, and a late CDB for tag 2 is ignored.
- query_tag1=2 with entry 2 busy/not ready and cdb_valid, cdb_tag=2, data=0xBEEF in the same cycle → query_ready1=1, query_data1=0xBEEF. query_tag2=0 → query_ready2=0.
- Hold rdy_in=0 for 3 cycles while the head is ready → no commit_valid, pointers unchanged. On release, the commit occurs one edge later. Asserting rst_in=0 mid-stream → outputs clear asynchronously, count=0.
